// File: rtl/counter_monitor.sv
// counter_monitor: cycle-accurate reference checker for a loadable up/down counter.
module counter_monitor #(
  parameter int BIT_WIDTH = 4,
  parameter int ERR_W = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 dut_reset,
  input  logic                 dut_chnge,
  input  logic [BIT_WIDTH-1:0] dut_load,
  input  logic [BIT_WIDTH-1:0] dut_count,
  output logic [BIT_WIDTH-1:0] exp_count,
  output logic                 synced,
  output logic                 mismatch,
  output logic                 err_sticky,
  output logic [ERR_W-1:0]     err_count,
  output logic [BIT_WIDTH-1:0] first_bad,
  output logic                 fail
);
  typedef enum logic [1:0] {UNSYNC, TRACK, FAIL} state_t;
  state_t state;
  logic [BIT_WIDTH-1:0] from_exp, from_obs;
  always_comb begin
    from_exp = dut_reset ? dut_load : dut_chnge ? exp_count - BIT_WIDTH'(1) : exp_count + BIT_WIDTH'(1);
    from_obs = dut_reset ? dut_load : dut_chnge ? dut_count - BIT_WIDTH'(1) : dut_count + BIT_WIDTH'(1);
  end
  assign synced = state == TRACK;
  assign fail = state == FAIL;
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= UNSYNC;
      exp_count <= '0;
      mismatch <= 1'b0;
      err_sticky <= 1'b0;
      err_count <= '0;
      first_bad <= '0;
    end else begin
      case (state)
        UNSYNC: begin
          mismatch <= 1'b0;
          if (dut_reset) begin
            exp_count <= dut_load;
            state <= TRACK;
          end
        end
        TRACK: begin
          if (dut_count == exp_count) begin
            exp_count <= from_exp;
            mismatch <= 1'b0;
          end else begin
            mismatch <= 1'b1;
            err_count <= &err_count ? err_count : err_count + ERR_W'(1);
            err_sticky <= 1'b1;
            if (!err_sticky) first_bad <= dut_count;
            // resync to the observed value so one glitch yields one error
            if (STOP_ON_ERR) state <= FAIL;
            else exp_count <= from_obs;
          end
        end
        default: mismatch <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor: scoreboard bench driving three monitor configurations with shared stimulus.
module tb_counter_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, dr, ch;
  logic [3:0] ld, dc;
  logic [3:0] e0, e1, e2, fb0, fb1, fb2;
  logic s0, s1, s2, m0, m1, m2, st0, st1, st2, f0, f1, f2;
  logic [7:0] ec0, ec1;
  logic [1:0] ec2;
  counter_monitor #(.BIT_WIDTH(4), .ERR_W(8), .STOP_ON_ERR(1'b0)) d0 (.CLK(clk), .reset(rst), .dut_reset(dr),
    .dut_chnge(ch), .dut_load(ld), .dut_count(dc), .exp_count(e0), .synced(s0), .mismatch(m0),
    .err_sticky(st0), .err_count(ec0), .first_bad(fb0), .fail(f0));
  counter_monitor #(.BIT_WIDTH(4), .ERR_W(8), .STOP_ON_ERR(1'b1)) d1 (.CLK(clk), .reset(rst), .dut_reset(dr),
    .dut_chnge(ch), .dut_load(ld), .dut_count(dc), .exp_count(e1), .synced(s1), .mismatch(m1),
    .err_sticky(st1), .err_count(ec1), .first_bad(fb1), .fail(f1));
  counter_monitor #(.BIT_WIDTH(4), .ERR_W(2), .STOP_ON_ERR(1'b0)) d2 (.CLK(clk), .reset(rst), .dut_reset(dr),
    .dut_chnge(ch), .dut_load(ld), .dut_count(dc), .exp_count(e2), .synced(s2), .mismatch(m2),
    .err_sticky(st2), .err_count(ec2), .first_bad(fb2), .fail(f2));
  typedef struct {int e; int s; int m; int st; int ec; int fb; int f;} exp_t;
  exp_t q0[$], q1[$], q2[$];
  int total = 0, bad = 0;
  int m_exp[3], m_err[3], m_fb[3], m_sync[3], m_fail[3], m_st[3], m_mis[3];
  int stop[3] = '{0, 1, 0};
  int emax[3] = '{255, 255, 3};
  function automatic int nx(int v, bit r, bit c, int l);
    return r ? l : c ? (v + 15) % 16 : (v + 1) % 16;
  endfunction
  function automatic logic [3:0] ex0();
    return 4'(m_exp[0]);
  endfunction
  task automatic cmp(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask
  task automatic chk(string n, exp_t x, int e, int s, int m, int st, int ec, int fb, int f);
    cmp({n, ".exp_count"}, e, x.e);
    cmp({n, ".synced"}, s, x.s);
    cmp({n, ".mismatch"}, m, x.m);
    cmp({n, ".err_sticky"}, st, x.st);
    cmp({n, ".err_count"}, ec, x.ec);
    cmp({n, ".first_bad"}, fb, x.fb);
    cmp({n, ".fail"}, f, x.f);
  endtask
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q0.size() != 0) begin x = q0.pop_front(); chk("stop0", x, e0, s0, m0, st0, ec0, fb0, f0); end
    if (q1.size() != 0) begin x = q1.pop_front(); chk("stop1", x, e1, s1, m1, st1, ec1, fb1, f1); end
    if (q2.size() != 0) begin x = q2.pop_front(); chk("errw2", x, e2, s2, m2, st2, ec2, fb2, f2); end
  end
  task automatic step(bit r, bit l, bit c, logic [3:0] lv, logic [3:0] cv);
    @(negedge clk);
    rst = r; dr = l; ch = c; ld = lv; dc = cv;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_exp[k] = 0; m_err[k] = 0; m_fb[k] = 0; m_sync[k] = 0; m_fail[k] = 0; m_st[k] = 0; m_mis[k] = 0;
      end else if (m_fail[k] != 0 || m_sync[k] == 0) begin
        m_mis[k] = 0;
        if (m_fail[k] == 0 && l) begin m_exp[k] = lv; m_sync[k] = 1; end
      end else if (int'(cv) == m_exp[k]) begin
        m_exp[k] = nx(m_exp[k], l, c, lv);
        m_mis[k] = 0;
      end else begin
        m_mis[k] = 1;
        m_err[k] = (m_err[k] < emax[k]) ? m_err[k] + 1 : emax[k];
        if (m_st[k] == 0) m_fb[k] = cv;
        m_st[k] = 1;
        if (stop[k] != 0) begin m_fail[k] = 1; m_sync[k] = 0; end
        else m_exp[k] = nx(cv, l, c, lv);
      end
    end
    q0.push_back('{m_exp[0], m_sync[0], m_mis[0], m_st[0], m_err[0], m_fb[0], m_fail[0]});
    q1.push_back('{m_exp[1], m_sync[1], m_mis[1], m_st[1], m_err[1], m_fb[1], m_fail[1]});
    q2.push_back('{m_exp[2], m_sync[2], m_mis[2], m_st[2], m_err[2], m_fb[2], m_fail[2]});
  endtask
  initial begin
    rst = 1'b1; dr = 1'b0; ch = 1'b0; ld = '0; dc = '0;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 12, 0);
    repeat (6) step(0, 0, 0, 0, ex0());
    step(0, 1, 1, 1, ex0());
    repeat (3) step(0, 0, 1, 0, ex0());
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 5, 0);
    step(0, 0, 0, 0, 5);
    step(0, 0, 0, 0, 6);
    step(0, 0, 0, 0, 9);
    repeat (4) step(0, 0, 0, 0, ex0());
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1'($urandom), 4'($urandom), 4'($urandom));
    step(0, 1, 0, 2, 0);
    repeat (3) step(0, 0, 0, 0, ex0() ^ 4'h8);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, ex0() ^ 4'h4);
    step(0, 1, 0, 3, ex0() ^ 4'h1);
    repeat (2) step(0, 0, 0, 0, ex0());
    for (int i = 0; i < 600; i++)
      step($urandom_range(49) == 0, $urandom_range(7) == 0, 1'($urandom), 4'($urandom),
           $urandom_range(3) == 0 ? 4'($urandom) : ex0());
    for (int i = 0; i < 5 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(posedge clk);
    #2;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Synthesizable checker attached to the counter interface (CLK, reset, chnge, load, count), at the far end from the stimulus driver.
- Holds a cycle-accurate reference model of the loadable up/down counter and compares it every cycle against the counter's observed output.
- Flags and counts mismatches so that a bench, or on-chip debug logic, can report pass/fail without waveform inspection.

Parameters:
- BIT_WIDTH, 4, width of the monitored counter and its load value.
- ERR_W, 8, width of the error counter, which saturates.
- STOP_ON_ERR, 0. When 1, the first mismatch freezes the monitor in FAIL. When 0, the monitor resynchronises and keeps checking.

Ports:
- CLK  in  1  Shared clock; all logic is on its rising edge.
- reset  in  1  Synchronous active-high reset of the monitor itself.
- dut_reset  in  1  Observed counter control: load request.
- dut_chnge  in  1  Observed direction: 0 = up, 1 = down.
- dut_load  in  BIT_WIDTH  Observed load value.
- dut_count  in  BIT_WIDTH  Observed counter output.
- exp_count  out  BIT_WIDTH  Model's expected count for the current cycle.
- synced  out  1  High while in TRACK.
- mismatch  out  1  One-cycle pulse: the previous edge's compare failed.
- err_sticky  out  1  Set on the first mismatch; cleared only by reset.
- err_count  out  ERR_W  Number of mismatches, saturating at all-ones.
- first_bad  out  BIT_WIDTH  dut_count value captured at the first mismatch.
- fail  out  1  High in FAIL.

Behaviour:
- Reset (reset=1 at an edge):
  - state=UNSYNC.
  - exp_count=0, synced=0, mismatch=0, err_sticky=0, err_count=0, first_bad=0, fail=0.
  - reset has priority over every other input.
- Monitored counter semantics, per edge:
  - dut_reset=1: next = dut_load.
  - Else dut_chnge=0: next = count+1, mod 2^BIT_WIDTH (all-ones wraps to 0).
  - Else: next = count-1, mod 2^BIT_WIDTH (0 wraps to all-ones).
- States:
  - UNSYNC: no compare is made; mismatch stays 0.
    - On an edge with dut_reset=1: exp_count<=dut_load, go to TRACK.
    - Otherwise stay in UNSYNC; exp_count holds.
  - TRACK: at each edge, compare dut_count against the current exp_count (one compare per cycle).
    - Equal: exp_count<=next(exp_count); mismatch<=0.
    - Not equal: mismatch<=1; err_count<=sat(err_count+1); err_sticky<=1.
      - If err_sticky was 0, first_bad<=dut_count.
      - STOP_ON_ERR=0: exp_count<=next(dut_count) (resync to the observed value), stay in TRACK.
      - STOP_ON_ERR=1: go to FAIL; exp_count holds.
    - A dut_reset=1 in the same edge as a mismatch: the mismatch is still recorded, and exp_count<=dut_load (load wins over resync).
  - FAIL: all registers hold, mismatch=0, fail=1. Only reset exits FAIL.
- Output decode: synced=1 exactly in TRACK; fail=1 exactly in FAIL.
- Latency: mismatch goes high in the cycle after the edge that sampled the bad dut_count.
- err_count at all-ones stays all-ones on further mismatches; err_sticky stays 1.
- dut_load and dut_chnge are ignored unless used by the transition rules above. X on dut_* in UNSYNC has no effect.

Test Plan:
- Sync and count up (BIT_WIDTH=4):
  - Stimulus: reset 1 cycle; dut_reset=1 with dut_load=12 for 1 edge; then dut_chnge=0 with a correct DUT for 6 edges.
  - Required: synced=1 after the load edge; exp_count runs 12,13,14,15,0,1,2; mismatch never 1; err_count=0.
- Down wrap:
  - Stimulus: load 1, then dut_chnge=1 for 3 edges.
  - Required: exp_count runs 1,0,15,14; no mismatch.
- Injected error, STOP_ON_ERR=0:
  - Stimulus: after loading 5 and counting up, force dut_count=9 when 7 is expected.
  - Required: mismatch pulse for exactly 1 cycle; err_count=1; first_bad=9; next exp_count=10; subsequent correct counting from 10 gives no further errors.
- Injected error, STOP_ON_ERR=1:
  - Stimulus: same error injection.
  - Required: fail=1 and synced=0 from the next cycle; exp_count frozen at 7; further wrong values do not change err_count=1.
- Unsynced and reset mid-operation:
  - Stimulus: wrong dut_count before any dut_reset; then reset asserted while in TRACK with err_count=3.
  - Required: no mismatch while unsynced; after reset all outputs are 0 and state is UNSYNC.
- Saturation and simultaneous events:
  - Stimulus: ERR_W=2; 5 mismatches; also a mismatch in the same edge as dut_reset=1 with dut_load=3.
  - Required: err_count stops at 3; the simultaneous edge records the mismatch and exp_count=3.
